// File: rtl/input_channel_buffers_pkg.sv
// Shared types and defaults for the PE input channel buffers.
// Defaults are sized for a 4-channel PE with 32-bit words and 4-bit tags.
package input_channel_buffers_pkg;

  localparam int TIA_NUM_INPUT_CHANNELS   = 4;
  localparam int TIA_WORD_WIDTH           = 32;
  localparam int TIA_TAG_WIDTH            = 4;
  localparam int TIA_CHANNEL_BUFFER_DEPTH = 4;

  typedef struct packed {
    logic [TIA_TAG_WIDTH-1:0]  tag;
    logic [TIA_WORD_WIDTH-1:0] word;
  } channel_entry_t;

  // Pointer advance with an explicit wrap, so DEPTH need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/input_channel_buffers_if.sv
// Channel-side bus of the input channel buffers: upstream link handshake plus the
// head/dequeue view used by trigger resolution and source fetch.
interface input_channel_buffers_if
  import input_channel_buffers_pkg::*;
#(
  parameter int NUM_CHANNELS = TIA_NUM_INPUT_CHANNELS,
  parameter int WORD_WIDTH   = TIA_WORD_WIDTH,
  parameter int TAG_WIDTH    = TIA_TAG_WIDTH
);

  // Handshake: a word transfers on channel c at a rising edge where upstream_valid[c] and
  // upstream_ready[c] are both high; the sender holds data/tag stable while valid && !ready.
  logic [NUM_CHANNELS-1:0]                 upstream_valid;
  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] upstream_data;
  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  upstream_tag;
  logic [NUM_CHANNELS-1:0]                 upstream_ready;
  logic [NUM_CHANNELS-1:0]                 dequeue;
  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] input_channel_data;
  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  input_channel_tag;
  logic [NUM_CHANNELS-1:0]                 input_channel_empty;

  modport master (
    output upstream_valid, upstream_data, upstream_tag, dequeue,
    input  upstream_ready, input_channel_data, input_channel_tag, input_channel_empty
  );

  modport slave (
    input  upstream_valid, upstream_data, upstream_tag, dequeue,
    output upstream_ready, input_channel_data, input_channel_tag, input_channel_empty
  );

endinterface

// File: rtl/input_channel_buffers_channel_fifo.sv
// Single-channel tagged FIFO: unreset storage, wrapping pointers, registered occupancy.
// Head is a combinational read of the oldest entry, forced to zero when empty.
module channel_fifo
  import input_channel_buffers_pkg::*;
#(
  parameter int DEPTH      = TIA_CHANNEL_BUFFER_DEPTH,
  parameter int WORD_WIDTH = TIA_WORD_WIDTH,
  parameter int TAG_WIDTH  = TIA_TAG_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [WORD_WIDTH-1:0] push_word,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  output logic                  push_ready,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] head_word,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [WORD_WIDTH-1:0] word;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign push_ready = (count != CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= '{tag: push_tag, word: push_word};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
      end
      if (do_pop) begin
        rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign head_word = empty ? '0 : head.word;
  assign head_tag  = empty ? '0 : head.tag;

endmodule

// File: rtl/input_channel_buffers.sv
// Per-channel input FIFOs between the interconnect and the PE datapath, plus the registered
// dequeue-on-empty flag. Optional per-channel stall counters: TIA_INPUT_CHANNEL_STALL_COUNT_EN.
module input_channel_buffers
  import input_channel_buffers_pkg::*;
#(
  parameter int NUM_CHANNELS = TIA_NUM_INPUT_CHANNELS,
  parameter int DEPTH        = TIA_CHANNEL_BUFFER_DEPTH,
  parameter int WORD_WIDTH   = TIA_WORD_WIDTH,
  parameter int TAG_WIDTH    = TIA_TAG_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input_channel_buffers_if.slave   bus,
  output logic                     dequeue_error
`ifdef TIA_INPUT_CHANNEL_STALL_COUNT_EN
  , output logic [NUM_CHANNELS-1:0][31:0] stall_count
`endif
);

  logic [NUM_CHANNELS-1:0]                 ready;
  logic [NUM_CHANNELS-1:0]                 empty;
  logic [NUM_CHANNELS-1:0][WORD_WIDTH-1:0] head_word;
  logic [NUM_CHANNELS-1:0][TAG_WIDTH-1:0]  head_tag;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_channel
    channel_fifo #(
      .DEPTH      (DEPTH),
      .WORD_WIDTH (WORD_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_valid (bus.upstream_valid[c]),
      .push_word  (bus.upstream_data[c]),
      .push_tag   (bus.upstream_tag[c]),
      .push_ready (ready[c]),
      .pop        (bus.dequeue[c]),
      .head_word  (head_word[c]),
      .head_tag   (head_tag[c]),
      .empty      (empty[c])
    );
  end

  assign bus.upstream_ready      = ready;
  assign bus.input_channel_empty = empty;
  assign bus.input_channel_data  = head_word;
  assign bus.input_channel_tag   = head_tag;

  // Any channel asked to pop while holding nothing raises the flag for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dequeue_error <= 1'b0;
    end else begin
      dequeue_error <= |(bus.dequeue & empty);
    end
  end

`ifdef TIA_INPUT_CHANNEL_STALL_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (bus.upstream_valid[c] && !ready[c] && (stall_count[c] != '1)) begin
          stall_count[c] <= stall_count[c] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
